divider_rv: RTL

//  Parametrised multi-cycle RV-M divider for DIV/DIVU/REM/REMU. Restoring radix-2 core, one bit/cycle.

---
 rtl/div_pkg.sv | 31 +++
 rtl/lead_one_det.sv | 25 ++
 rtl/divider_rv.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider_rv RV-M divide unit.
package div_pkg;

    // Operation encoding matches funct3[1:0] of the RV-M divide group.
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    // Control FSM states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_BUSY = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // DIV and REM treat operands as two's complement.
    function automatic logic op_is_signed(div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    // REM and REMU return the remainder on res_o.
    function automatic logic op_is_rem(div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/lead_one_det.sv
// Combinational leading-one detector: index of the most significant set bit
// plus a flag for an all-zero input. Used by the early-out build of divider_rv.
module lead_one_det
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         x,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     zero
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        idx  = '0;
        zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                idx  = i[$clog2(WIDTH)-1:0];
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/divider_rv.sv
// divider_rv: multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; signed ops run on magnitudes and are corrected
// in FIX. Divide-by-zero and signed overflow bypass the iteration loop.
//
// Handshake: a request is taken on a clock edge where vld_i & rdy_o are high
// and flush_i is low. A result is held on res_* / tag_o from the first cycle
// res_vld_o is high until the edge where res_vld_o & res_rdy_i are both high.
//
// Optional feature macro: DIVIDER_RV_EARLY_OUT_EN. When defined, PREP uses two
// leading-one detectors to skip quotient bits that are known to be zero.
module divider_rv
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             vld_i,
    output logic             rdy_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] div1_i,
    input  logic [WIDTH-1:0] div2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             res_vld_o,
    input  logic             res_rdy_i,
    output logic [WIDTH-1:0] res_o,
    output logic [WIDTH-1:0] res_q_o,
    output logic [WIDTH-1:0] res_r_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state_q, state_d;
    div_op_t           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [WIDTH-1:0]  a_q;      // raw dividend
    logic [WIDTH-1:0]  b_q;      // raw divisor, replaced by |divisor| in PREP
    logic [WIDTH-1:0]  rem_q;    // partial remainder (always < divisor)
    logic [WIDTH-1:0]  quo_q;    // dividend bits shifting out, quotient bits shifting in
    logic [CW-1:0]     cnt_q;
    logic              sign_q_q, sign_r_q, special_q;

    logic              accept;
    logic              is_signed, b_zero, ovf, special;
    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [CW-1:0]     iter;
    logic [WIDTH-1:0]  rem_init, quo_init;
    logic [WIDTH:0]    rem_sh;
    logic              no_borrow;
    logic [WIDTH-1:0]  rem_sub;
    logic [WIDTH-1:0]  q_fin, r_fin;

    assign accept = vld_i & rdy_o & ~flush_i;

    // Operand conditioning evaluated while in PREP.
    always_comb begin
        is_signed = op_is_signed(op_q);
        abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        b_zero    = (b_q == '0);
        ovf       = is_signed && (a_q == MIN_VAL) && (b_q == '1);
        special   = b_zero | ovf;
    end

`ifdef DIVIDER_RV_EARLY_OUT_EN
    logic [$clog2(WIDTH)-1:0] msb_a, msb_b;
    logic                     zero_a, zero_b;

    lead_one_det #(.WIDTH(WIDTH)) u_lod_a (.x(abs_a), .idx(msb_a), .zero(zero_a));
    lead_one_det #(.WIDTH(WIDTH)) u_lod_b (.x(abs_b), .idx(msb_b), .zero(zero_b));

    // Only bits msb(a)-msb(b) .. 0 of the quotient can be set; at least one pass.
    always_comb begin
        iter = CW'(1);
        if (!zero_a && !zero_b && (msb_a >= msb_b))
            iter = CW'(msb_a) - CW'(msb_b) + CW'(1);
    end

    // Pre-align: the dividend bits above the first iteration go straight into
    // the remainder, which is guaranteed smaller than the divisor.
    assign rem_init = abs_a >> iter;
    assign quo_init = abs_a << (CW'(WIDTH) - iter);
`else
    assign iter     = CW'(WIDTH);
    assign rem_init = '0;
    assign quo_init = abs_a;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        no_borrow = (rem_sh >= {1'b0, b_q});
        rem_sub   = rem_sh[WIDTH-1:0] - b_q;
    end

    // Sign correction; special-case results are already final.
    always_comb begin
        q_fin = (sign_q_q && !special_q) ? -quo_q : quo_q;
        r_fin = (sign_r_q && !special_q) ? -rem_q : rem_q;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; flush_i overrides everything, including an accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_PREP;
            S_PREP: state_d = special ? S_FIX : S_BUSY;
            S_BUSY: if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: begin
                if (accept)         state_d = S_PREP;
                else if (res_rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // FSM outputs.
    always_comb begin
        rdy_o     = (state_q == S_IDLE) || ((state_q == S_DONE) && res_rdy_i);
        res_vld_o = (state_q == S_DONE);
        busy_o    = (state_q != S_IDLE);
    end

    // Datapath: capture request, condition operands, iterate, publish result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= DIV;
            tag_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            special_q <= 1'b0;
            res_o     <= '0;
            res_q_o   <= '0;
            res_r_o   <= '0;
            tag_o     <= '0;
        end else begin
            if (accept) begin
                op_q  <= div_op_t'(op_i);
                tag_q <= tag_i;
                a_q   <= div1_i;
                b_q   <= div2_i;
            end
            case (state_q)
                S_PREP: begin
                    sign_q_q  <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & ~b_zero;
                    sign_r_q  <= is_signed & a_q[WIDTH-1];
                    special_q <= special;
                    b_q       <= abs_b;
                    cnt_q     <= iter;
                    if (b_zero) begin
                        quo_q <= '1;
                        rem_q <= a_q;
                    end else if (ovf) begin
                        quo_q <= MIN_VAL;
                        rem_q <= '0;
                    end else begin
                        quo_q <= quo_init;
                        rem_q <= rem_init;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (no_borrow) begin
                        rem_q <= rem_sub;
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    res_q_o <= q_fin;
                    res_r_o <= r_fin;
                    res_o   <= op_is_rem(op_q) ? r_fin : q_fin;
                    tag_o   <= tag_q;
                end
                default: ;
            endcase
        end
    end

endmodule
